// File: rtl/misaligned_access_unit.sv
// Misaligned load/store splitter between the execute stage and a byte-addressed data memory.
// Aligned accesses pass straight through combinationally. Misaligned LW/LH/LHU/SW/SH are
// broken into N single-byte beats (N=4 for words, N=2 for halves) while stall holds the core;
// load bytes are gathered into asm_q and presented, extended, in the DONE cycle.
// Optional feature: define MISALIGN_CNT_EN to add the saturating misalignCount output.

module misaligned_access_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] aluOut,
  input  logic [31:0] data2,
  input  logic [2:0]  func3,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memData,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [2:0]  memFunc3,
  output logic        memReadOut,
  output logic        memWriteOut,
  output logic [31:0] loadData,
  output logic        stall
`ifdef MISALIGN_CNT_EN
  ,
  output logic [15:0] misalignCount
`endif
);

  typedef enum logic [1:0] {StIdle, StSplit, StDone} state_e;

  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lhu = 3'b101;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] asm_q;
  logic [2:0]  f3_q;
  logic        load_q;

  logic              is_word;
  logic              is_half;
  logic              mis;
  logic [1:0]        last_beat;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] beat_low;
  logic [7:0]        store_byte;
  logic [31:0]       done_data;

  // Decode misalignment and the current beat from the live inputs.
  always_comb begin
    is_word    = (func3 == F3Lw);
    is_half    = (func3 == F3Lh) || (func3 == F3Lhu);
    mis        = (memRead ^ memWrite) &&
                 ((is_word && (aluOut[1:0] != 2'b00)) || (is_half && aluOut[0]));
    last_beat  = is_word ? 2'd3 : 2'd1;
    beat       = (state_q == StIdle) ? 2'd0 : cnt_q;
    // Beat address wraps inside the decoded window; upper bits are carried unchanged.
    beat_low   = aluOut[ADDR_W-1:0] + ADDR_W'(beat);
    store_byte = data2[{beat, 3'b000} +: 8];
  end

  // Final load value from the gathered bytes, using the width captured at split start.
  always_comb begin
    done_data = 32'h0;
    if (load_q) begin
      case (f3_q)
        F3Lw:    done_data = asm_q;
        F3Lh:    done_data = {{16{asm_q[15]}}, asm_q[15:0]};
        F3Lhu:   done_data = {16'h0, asm_q[15:0]};
        default: done_data = 32'h0;
      endcase
    end
  end

  // Memory-side outputs: pass-through by default, byte beats while splitting.
  always_comb begin
    memAddr     = aluOut;
    memWData    = data2;
    memFunc3    = func3;
    memReadOut  = memRead;
    memWriteOut = memWrite;
    loadData    = memData;
    stall       = 1'b0;
    if (!rst_n) begin
      memReadOut  = 1'b0;
      memWriteOut = 1'b0;
      loadData    = 32'h0;
    end else if ((state_q == StSplit) || ((state_q == StIdle) && mis)) begin
      stall   = 1'b1;
      memAddr = {aluOut[31:ADDR_W], beat_low};
      if (memRead) begin
        memFunc3    = F3Lbu;
        memReadOut  = 1'b1;
        memWriteOut = 1'b0;
      end else begin
        memFunc3    = F3Sb;
        memReadOut  = 1'b0;
        memWriteOut = 1'b1;
        memWData    = {24'h0, store_byte};
      end
    end else if (state_q == StDone) begin
      memReadOut  = 1'b0;
      memWriteOut = 1'b0;
      loadData    = done_data;
    end
  end

  // Split sequencer: beat counter, byte gathering and captured access kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      asm_q   <= 32'h0;
      f3_q    <= 3'b000;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mis) begin
            state_q <= StSplit;
            cnt_q   <= 2'd1;
            f3_q    <= func3;
            load_q  <= memRead;
            if (memRead) asm_q[7:0] <= memData[7:0];
          end
        end
        StSplit: begin
          if (memRead) asm_q[{cnt_q, 3'b000} +: 8] <= memData[7:0];
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == last_beat) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= 2'd0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 2'd0;
        end
      endcase
    end
  end

`ifdef MISALIGN_CNT_EN
  logic [15:0] mis_cnt_q;

  // Count completed splits, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_cnt_q <= 16'h0;
    end else if ((state_q == StSplit) && (cnt_q == last_beat) && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_q <= mis_cnt_q + 16'd1;
    end
  end

  assign misalignCount = mis_cnt_q;
`endif

endmodule

// File: tb/tb_misaligned_access_unit.sv
// Self-checking bench for misaligned_access_unit: byte memory model on the memory side,
// byte-array reference model for expected load values, beat counts and memory image.

module tb_misaligned_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aluOut, data2, memData, memAddr, memWData, loadData;
  logic [2:0]  func3, memFunc3;
  logic        memRead, memWrite, memReadOut, memWriteOut, stall;
`ifdef MISALIGN_CNT_EN
  logic [15:0] misalignCount;
  int          exp_cnt = 0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  misaligned_access_unit #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aluOut      (aluOut),
    .data2       (data2),
    .func3       (func3),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memData     (memData),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memFunc3    (memFunc3),
    .memReadOut  (memReadOut),
    .memWriteOut (memWriteOut),
    .loadData    (loadData),
    .stall       (stall)
`ifdef MISALIGN_CNT_EN
    ,
    .misalignCount (misalignCount)
`endif
  );

  // Data memory seen by the DUT (1 KiB, combinational read, extended per width code).
  logic [7:0] mem [1024] = '{default: 8'h00};

  always_comb begin
    logic [9:0]  a;
    logic [31:0] w;
    a = memAddr[9:0];
    w = {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    memData = w;
    case (memFunc3)
      3'b000:  memData = {{24{w[7]}}, w[7:0]};
      3'b001:  memData = {{16{w[15]}}, w[15:0]};
      3'b100:  memData = {24'h0, w[7:0]};
      3'b101:  memData = {16'h0, w[15:0]};
      default: memData = w;
    endcase
  end

  always @(posedge clk) begin
    if (memWriteOut) begin
      mem[memAddr[9:0]] <= memWData[7:0];
      if (memFunc3 != 3'b000) mem[memAddr[9:0] + 10'd1] <= memWData[15:8];
      if (memFunc3 == 3'b010) begin
        mem[memAddr[9:0] + 10'd2] <= memWData[23:16];
        mem[memAddr[9:0] + 10'd3] <= memWData[31:24];
      end
    end
  end

  // Reference model: architectural byte image plus the splitting rules.
  logic [7:0] ref_mem [1024] = '{default: 8'h00};

  function automatic int width_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b10) return 4;
    if (f3[1:0] == 2'b01) return 2;
    return 1;
  endfunction

  function automatic int exp_beats(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 4;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = width_bytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + k) % 1024]) << (8 * k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < width_bytes(f3); k++) ref_mem[(a + k) % 1024] = 8'(d >> (8 * k));
  endtask

  // Drive one access starting just after a rising edge; return the value seen in the
  // retire cycle and the number of stalled cycles. Leaves time just after a rising edge.
  task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] val, output int cyc);
    memRead  = ld;
    memWrite = !ld;
    func3    = f3;
    aluOut   = a;
    data2    = d;
    cyc      = 0;
    @(negedge clk);
    while (stall === 1'b1 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    val = loadData;
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    memRead  = 1'b1;
    memWrite = 1'b0;
    func3    = 3'b010;
    aluOut   = 32'h1;
    data2    = 32'h0;
    #3;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall got %b want 0", stall);
    end
    tests++;
    if ({memReadOut, memWriteOut} !== 2'b00) begin
      fails++; $display("FAIL reset_strobes got %b want 00", {memReadOut, memWriteOut});
    end
    tests++;
    if (loadData !== 32'h0) begin
      fails++; $display("FAIL reset_loaddata got %h want 0", loadData);
    end
    @(negedge clk);
    memRead = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned;
    logic [31:0] v;
    int c;
    do_access(1'b0, 3'b010, 32'h8, 32'h1122_3344, v, c);
    ref_store(3'b010, 32'h8, 32'h1122_3344);
    tests++;
    if (c != 0) begin
      fails++; $display("FAIL aligned_sw_stall got %0d want 0", c);
    end
    do_access(1'b1, 3'b010, 32'h8, 32'h0, v, c);
    tests++;
    if (c != 0) begin
      fails++; $display("FAIL aligned_lw_stall got %0d want 0", c);
    end
    tests++;
    if (v !== 32'h1122_3344) begin
      fails++; $display("FAIL aligned_lw_data got %h want 11223344", v);
    end
  endtask

  task automatic test_split_store;
    logic [31:0] v;
    logic [31:0] d;
    int c;
    d        = 32'hAABB_CCDD;
    memRead  = 1'b0;
    memWrite = 1'b1;
    func3    = 3'b010;
    aluOut   = 32'h1;
    data2    = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if ({stall, memWriteOut, memReadOut, memFunc3} !== 6'b110_000 ||
          memAddr !== 32'(1 + k) || memWData !== {24'h0, 8'(d >> (8 * k))}) begin
        fails++;
        $display("FAIL split_sw_beat%0d got stall=%b we=%b re=%b f3=%b addr=%h wd=%h want addr=%h",
                 k, stall, memWriteOut, memReadOut, memFunc3, memAddr, memWData, 32'(1 + k));
      end
    end
    @(negedge clk);
    tests++;
    if ({stall, memWriteOut, memReadOut} !== 3'b000 || loadData !== 32'h0) begin
      fails++;
      $display("FAIL split_sw_done got stall=%b we=%b re=%b ld=%h want 0/0/0/0",
               stall, memWriteOut, memReadOut, loadData);
    end
    @(posedge clk);
    #1;
    memWrite = 1'b0;
    ref_store(3'b010, 32'h1, d);
`ifdef MISALIGN_CNT_EN
    exp_cnt++;
`endif
    do_access(1'b1, 3'b010, 32'h1, 32'h0, v, c);
`ifdef MISALIGN_CNT_EN
    exp_cnt++;
`endif
    tests++;
    if (c != 4) begin
      fails++; $display("FAIL split_lw_stall got %0d want 4", c);
    end
    tests++;
    if (v !== 32'hAABB_CCDD) begin
      fails++; $display("FAIL split_lw_data got %h want aabbccdd", v);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] v;
    int c;
    do_access(1'b0, 3'b000, 32'h3FF, 32'h80, v, c);
    ref_store(3'b000, 32'h3FF, 32'h80);
    do_access(1'b0, 3'b000, 32'h000, 32'hFF, v, c);
    ref_store(3'b000, 32'h000, 32'hFF);
    memRead  = 1'b1;
    memWrite = 1'b0;
    func3    = 3'b001;
    aluOut   = 32'h3FF;
    @(negedge clk);
    tests++;
    if (memAddr !== 32'h3FF || stall !== 1'b1) begin
      fails++; $display("FAIL wrap_beat0 got addr=%h stall=%b want 3ff/1", memAddr, stall);
    end
    @(negedge clk);
    tests++;
    if (memAddr !== 32'h000 || stall !== 1'b1 || memFunc3 !== 3'b100) begin
      fails++;
      $display("FAIL wrap_beat1 got addr=%h stall=%b f3=%b want 0/1/100", memAddr, stall, memFunc3);
    end
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || loadData !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL wrap_lh got stall=%b ld=%h want 0/ffffff80", stall, loadData);
    end
    @(posedge clk);
    #1;
    memRead = 1'b0;
    do_access(1'b1, 3'b101, 32'h3FF, 32'h0, v, c);
`ifdef MISALIGN_CNT_EN
    exp_cnt += 2;
`endif
    tests++;
    if (v !== 32'h0000_FF80 || c != 2) begin
      fails++; $display("FAIL wrap_lhu got %h/%0d want 0000ff80/2", v, c);
    end
  endtask

  task automatic test_both_strobes;
    memRead  = 1'b1;
    memWrite = 1'b1;
    func3    = 3'b010;
    aluOut   = 32'h1;
    data2    = 32'h5A5A_1234;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || memAddr !== 32'h1 || memFunc3 !== 3'b010 ||
        memWData !== 32'h5A5A_1234 || {memReadOut, memWriteOut} !== 2'b11) begin
      fails++;
      $display("FAIL both_passthru got stall=%b addr=%h f3=%b wd=%h re/we=%b%b",
               stall, memAddr, memFunc3, memWData, memReadOut, memWriteOut);
    end
    @(posedge clk);
    ref_store(3'b010, 32'h1, 32'h5A5A_1234);
    @(negedge clk);
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL both_nosplit got stall=%b want 0", stall);
    end
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    logic [31:0] d;
    int c;
    do_access(1'b0, 3'b010, 32'h100, 32'h0, v, c);
    ref_store(3'b010, 32'h100, 32'h0);
    do_access(1'b0, 3'b010, 32'h104, 32'h0, v, c);
    ref_store(3'b010, 32'h104, 32'h0);
    d        = $urandom | 32'h0101_0101;
    memRead  = 1'b0;
    memWrite = 1'b1;
    func3    = 3'b010;
    aluOut   = 32'h101;
    data2    = d;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({stall, memReadOut, memWriteOut} !== 3'b000 || loadData !== 32'h0) begin
      fails++;
      $display("FAIL midreset_outputs got stall=%b re=%b we=%b ld=%h want 0",
               stall, memReadOut, memWriteOut, loadData);
    end
    @(negedge clk);
    memWrite = 1'b0;
    rst_n    = 1'b1;
    ref_store(3'b001, 32'h101, d);
`ifdef MISALIGN_CNT_EN
    exp_cnt = 0;
`endif
    tests++;
    if ({mem[10'h104], mem[10'h103], mem[10'h102], mem[10'h101]} !==
        {ref_mem[32'h104], ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101]}) begin
      fails++;
      $display("FAIL midreset_bytes got %h want %h",
               {mem[10'h104], mem[10'h103], mem[10'h102], mem[10'h101]},
               {ref_mem[32'h104], ref_mem[32'h103], ref_mem[32'h102], ref_mem[32'h101]});
    end
    @(posedge clk);
    #1;
    do_access(1'b0, 3'b010, 32'h101, d, v, c);
    ref_store(3'b010, 32'h101, d);
`ifdef MISALIGN_CNT_EN
    exp_cnt++;
`endif
    tests++;
    if (c != 4) begin
      fails++; $display("FAIL midreset_restart got %0d want 4", c);
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] v, a, d, expv;
    logic [2:0]  f3;
    logic        ld;
    int          c, nb;
    for (int i = 0; i < 80; i++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? f3s[$urandom_range(0, 4)] : f3s[$urandom_range(0, 2)];
      a  = $urandom;
      d  = $urandom;
      nb = exp_beats(f3, a);
      expv = ref_load(f3, a);
      do_access(ld, f3, a, d, v, c);
      if (!ld) ref_store(f3, a, d);
`ifdef MISALIGN_CNT_EN
      if (nb > 0) exp_cnt++;
`endif
      tests++;
      if (c != nb) begin
        fails++; $display("FAIL rand%0d_stall f3=%b a=%h got %0d want %0d", i, f3, a, c, nb);
      end
      if (ld) begin
        tests++;
        if (v !== expv) begin
          fails++; $display("FAIL rand%0d_load f3=%b a=%h got %h want %h", i, f3, a, v, expv);
        end
      end else if (nb > 0) begin
        tests++;
        if (v !== 32'h0) begin
          fails++; $display("FAIL rand%0d_store_ld a=%h got %h want 0", i, a, v);
        end
      end
    end
  endtask

  task automatic test_mem_image;
    int bad;
    bad = -1;
    for (int i = 0; i < 1024; i++) if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++; $display("FAIL mem_image at %h got %h want %h", bad, mem[bad], ref_mem[bad]);
    end
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_split_store;
    test_wrap;
    test_both_strobes;
    test_reset_mid;
    test_random;
    test_mem_image;
`ifdef MISALIGN_CNT_EN
    tests++;
    if (misalignCount !== 16'(exp_cnt)) begin
      fails++; $display("FAIL mis_count got %0d want %0d", misalignCount, exp_cnt);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
